// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/halt controller with memory-wait timeout.
// Optional HAZARD_STATS_EN adds a saturating stall_cnt output.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        mem_busy,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
`ifdef HAZARD_STATS_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_DRAIN, S_HALTED} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_wait_cnt, w_wait_nxt;
  logic [3:0]  r_drain_cnt, w_drain_nxt;
  logic        r_timeout_err;
  logic        w_load_use;
  logic        w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic        w_ifid_flush, w_idex_flush;

  assign w_load_use = idex_MemRead && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    w_next       = r_state;
    w_wait_nxt   = r_wait_cnt;
    w_drain_nxt  = r_drain_cnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_busy) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b00000;
          w_next     = S_MEMWAIT;
          w_wait_nxt = 8'd1;
        end else begin
          if (branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end else if (jump) begin
            w_ifid_flush = 1'b1;
          end
          if (halt_req) begin
            w_next      = S_DRAIN;
            w_drain_nxt = 4'd0;
          end
        end
      end
      S_MEMWAIT: begin
        if (mem_busy) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b00000;
          if (r_wait_cnt != 8'hFF) w_wait_nxt = r_wait_cnt + 8'd1;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b00000;
        end else begin
          // Stop fetching and squash IF/ID while older instructions retire.
          w_pc_en      = 1'b0;
          w_ifid_flush = 1'b1;
          w_drain_nxt  = r_drain_cnt + 4'd1;
          if (r_drain_cnt == 4'(DRAIN_CYCLES - 1)) w_next = S_HALTED;
        end
      end
      S_HALTED: begin
        {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b00000;
        if (resume) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
    // Outputs go to free-running defaults as soon as reset asserts, not at the next edge.
    if (!reset_n) begin
      {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= 8'd0;
      r_drain_cnt   <= 4'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wait_cnt  <= w_wait_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_wait_nxt == 8'(MEM_TIMEOUT)) r_timeout_err <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'd0;
    end else if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid_en;
  assign idex_en     = w_idex_en;
  assign exmem_en    = w_exmem_en;
  assign memwb_en    = w_memwb_en;
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign halted      = (r_state == S_HALTED);
  assign timeout_err = r_timeout_err;

endmodule
